// File: rtl/body_type_classifier.sv
// Body type classifier: splits an input word into LANES body codes, flags each
// code as type-1 or type-0, and registers the per-lane flags and their popcount.
// A single result register sits behind a valid/ready handshake. Saturating
// running totals of type-1 lanes and accepted words are kept alongside it.

// Per-lane classifier. Combinational only; the parent registers the result.
module btc_lane #(
  parameter int CODE_W = 3
) (
  input  logic [CODE_W-1:0] code,
  input  logic              mode,
  input  logic [CODE_W-1:0] pattern,
  output logic              is_t1
);

  // mode 0 matches a uniform code, mode 1 matches the reference pattern
  always_comb begin
    is_t1 = 1'b0;
    if (mode) is_t1 = (code == pattern);
    else      is_t1 = (code == '0) || (code == '1);
  end

endmodule

module body_type_classifier #(
  parameter  int CODE_W = 3,
  parameter  int LANES  = 4,
  parameter  int CNT_W  = 8,
  localparam int OCW    = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [CODE_W-1:0]       pattern,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*CODE_W-1:0] in_codes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_types,
  output logic [OCW-1:0]          out_count,
  output logic [CNT_W-1:0]        tot_type1,
  output logic [CNT_W-1:0]        tot_words
);

  // Sum width large enough that neither the counter nor a full popcount can
  // overflow before the saturation compare.
  localparam int SW = ((CNT_W > OCW) ? CNT_W : OCW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [LANES-1:0] types;
    logic [OCW-1:0]   count;
  } res_t;

  state_t state, state_nxt;
  res_t   res_q, res_d;

  logic [LANES-1:0][CODE_W-1:0] codes;
  logic [LANES-1:0]             lane_t1;
  logic                         accept;
  logic                         deliver;
  logic [CNT_W-1:0]             base_t1, base_words;
  logic [SW-1:0]                sum_t1, sum_words;

  assign codes = in_codes;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      btc_lane #(.CODE_W(CODE_W)) u_lane (
        .code    (codes[gi]),
        .mode    (mode),
        .pattern (pattern),
        .is_t1   (lane_t1[gi])
      );
    end
  endgenerate

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign out_types = res_q.types;
  assign out_count = res_q.count;

  // Classification result of the word presented this cycle
  always_comb begin
    res_d       = '0;
    res_d.types = lane_t1;
    for (int i = 0; i < LANES; i++) res_d.count = res_d.count + OCW'(lane_t1[i]);
  end

  // Result register occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // EMPTY/FULL transitions; a simultaneous deliver+accept stays FULL
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (deliver && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Result payload loads only on acceptance, so mode/pattern changes while a
  // result is held cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst_n)      res_q <= '0;
    else if (accept) res_q <= res_d;
  end

  // A clear coinciding with an accept restarts the totals from this word
  always_comb begin
    base_t1    = clear ? '0 : tot_type1;
    base_words = clear ? '0 : tot_words;
    sum_t1     = SW'(base_t1) + SW'(res_d.count);
    sum_words  = SW'(base_words) + SW'(1);
  end

  // Saturating running totals
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tot_type1 <= '0;
      tot_words <= '0;
    end else if (accept) begin
      tot_type1 <= (sum_t1 > CNT_MAX) ? {CNT_W{1'b1}} : sum_t1[CNT_W-1:0];
      tot_words <= (sum_words > CNT_MAX) ? {CNT_W{1'b1}} : sum_words[CNT_W-1:0];
    end else if (clear) begin
      tot_type1 <= '0;
      tot_words <= '0;
    end
  end

endmodule

// File: tb/tb_body_type_classifier.sv
// Directed bench for body_type_classifier. Two instances share all inputs: one
// with default parameters, one with CNT_W=4 to reach counter saturation. A
// behavioural model predicts every output and is compared each negedge; literal
// expectations pin the model at key points.
module tb_body_type_classifier;

  localparam int CODE_W = 3;
  localparam int LANES  = 4;
  localparam int OCW    = 3;

  logic                    clk = 1'b0;
  logic                    rst_n, mode, clear, in_valid, out_ready;
  logic [CODE_W-1:0]       pattern;
  logic [LANES*CODE_W-1:0] in_codes;

  logic             in_ready, out_valid, in_ready2, out_valid2;
  logic [LANES-1:0] out_types, out_types2;
  logic [OCW-1:0]   out_count, out_count2;
  logic [7:0]       tot_type1, tot_words;
  logic [3:0]       tot_type1_2, tot_words_2;

  int checks = 0;
  int failures = 0;

  body_type_classifier dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pattern(pattern), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_codes(in_codes),
    .out_valid(out_valid), .out_ready(out_ready), .out_types(out_types),
    .out_count(out_count), .tot_type1(tot_type1), .tot_words(tot_words)
  );

  body_type_classifier #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pattern(pattern), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready2), .in_codes(in_codes),
    .out_valid(out_valid2), .out_ready(out_ready), .out_types(out_types2),
    .out_count(out_count2), .tot_type1(tot_type1_2), .tot_words(tot_words_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       started = 0;
  bit       m_valid;
  int       m_types, m_count;
  int       m_t8, m_w8, m_t4, m_w4;

  function automatic int classify(input logic [LANES*CODE_W-1:0] w,
                                  input logic md, input logic [CODE_W-1:0] p);
    int r = 0;
    for (int i = 0; i < LANES; i++) begin
      logic [CODE_W-1:0] c;
      c = w[i*CODE_W +: CODE_W];
      if (md ? (c == p) : (c == 3'b000 || c == 3'b111)) r += (1 << i);
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started = 1;
      m_valid = 0; m_types = 0; m_count = 0;
      m_t8 = 0; m_w8 = 0; m_t4 = 0; m_w4 = 0;
    end else if (started) begin
      bit acc;
      acc = in_valid && (!m_valid || out_ready);
      if (clear) begin
        m_t8 = 0; m_w8 = 0; m_t4 = 0; m_w4 = 0;
      end
      if (acc) begin
        int t;
        t = classify(in_codes, mode, pattern);
        m_types = t;
        m_count = $countones(t[LANES-1:0]);
        m_valid = 1;
        m_t8 = sat(m_t8 + m_count, 255); m_w8 = sat(m_w8 + 1, 255);
        m_t4 = sat(m_t4 + m_count, 15);  m_w4 = sat(m_w4 + 1, 15);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Single compare process against the model
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_valid2", out_valid2, m_valid);
      chk("in_ready", in_ready, (!m_valid || out_ready));
      chk("in_ready2", in_ready2, (!m_valid || out_ready));
      if (m_valid) begin
        chk("out_types", out_types, m_types);
        chk("out_count", out_count, m_count);
        chk("out_types2", out_types2, m_types);
        chk("out_count2", out_count2, m_count);
      end
      chk("tot_type1", tot_type1, m_t8);
      chk("tot_words", tot_words, m_w8);
      chk("tot_type1_2", tot_type1_2, m_t4);
      chk("tot_words_2", tot_words_2, m_w4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // directed table exercised with out_ready toggling
  logic [LANES*CODE_W-1:0] tbl_codes [8] = '{
    {3'b000, 3'b000, 3'b000, 3'b000}, {3'b001, 3'b010, 3'b100, 3'b110},
    {3'b011, 3'b011, 3'b111, 3'b011}, {3'b111, 3'b000, 3'b111, 3'b000},
    {3'b110, 3'b110, 3'b001, 3'b110}, {3'b101, 3'b010, 3'b101, 3'b010},
    {3'b000, 3'b111, 3'b011, 3'b100}, {3'b100, 3'b100, 3'b100, 3'b100}};
  logic       tbl_mode [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0] tbl_pat  [8] = '{3'b000, 3'b010, 3'b011, 3'b111, 3'b110, 3'b101, 3'b011, 3'b100};
  logic       tbl_ordy [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 0; mode = 0; pattern = '0; clear = 0; in_valid = 0;
    out_ready = 1; in_codes = '0;
    step(); step();
    chk("rst out_valid", out_valid, 0);
    chk("rst out_types", out_types, 0);
    chk("rst out_count", out_count, 0);
    chk("rst tot_type1", tot_type1, 0);
    chk("rst tot_words", tot_words, 0);
    rst_n = 1;
    step();
    chk("rel in_ready", in_ready, 1);

    // Lane 0 = 111, lane 1 = 000, lane 2 = 101, lane 3 = 010
    mode = 0; in_codes = {3'b010, 3'b101, 3'b000, 3'b111}; in_valid = 1;
    step(); in_valid = 0;
    chk("t1 out_valid", out_valid, 1);
    chk("t1 out_types", out_types, 4'b0011);
    chk("t1 out_count", out_count, 2);
    chk("t1 tot_type1", tot_type1, 2);
    chk("t1 tot_words", tot_words, 1);
    step();
    chk("t1 delivered", out_valid, 0);

    // Pattern mode versus uniform mode on the same word
    mode = 1; pattern = 3'b101; in_codes = {3'b101, 3'b101, 3'b111, 3'b000};
    in_valid = 1;
    step();
    chk("t2 pattern types", out_types, 4'b1100);
    chk("t2 pattern count", out_count, 2);
    mode = 0;
    step();
    chk("t2 uniform types", out_types, 4'b0011);
    in_valid = 0;
    step();

    // Back-pressure: held result is stable while inputs change
    out_ready = 0; mode = 1; pattern = 3'b111;
    in_codes = {3'b111, 3'b000, 3'b111, 3'b111}; in_valid = 1;
    step();
    chk("t3 held types", out_types, 4'b1011);
    chk("t3 held words", tot_words, 4);
    mode = 0; in_codes = '0;
    repeat (3) begin
      step();
      chk("t3 in_ready low", in_ready, 0);
      chk("t3 stable types", out_types, 4'b1011);
      chk("t3 stable words", tot_words, 4);
    end
    out_ready = 1;
    #1 chk("t3 in_ready high", in_ready, 1);
    step();
    chk("t3 replace types", out_types, 4'b1111);
    chk("t3 replace count", out_count, 4);
    chk("t3 replace words", tot_words, 5);
    chk("t3 replace type1", tot_type1, 13);
    in_valid = 0;
    step();

    // Clear alone leaves a held result in place
    out_ready = 0; in_codes = {4{3'b010}}; in_valid = 1;
    step(); in_valid = 0; clear = 1;
    step(); clear = 0;
    chk("t4 held after clear", out_valid, 1);
    chk("t4 cleared type1", tot_type1, 0);
    chk("t4 cleared words", tot_words, 0);
    out_ready = 1;
    step();

    // Clear coincident with accept loads the new word's totals
    in_codes = {4{3'b111}}; in_valid = 1;
    step();
    in_codes = {3'b010, 3'b111, 3'b000, 3'b111};
    step();
    chk("t5 pre type1", tot_type1, 7);
    chk("t5 pre words", tot_words, 2);
    clear = 1;
    step(); clear = 0;
    chk("t5 type1", tot_type1, 3);
    chk("t5 words", tot_words, 1);
    in_valid = 0;
    step();

    // Saturation on the CNT_W=4 instance
    clear = 1; step(); clear = 0;
    in_codes = {4{3'b111}}; in_valid = 1;
    repeat (4) step();
    chk("t6 sat type1", tot_type1_2, 15);
    chk("t6 sat words", tot_words_2, 4);
    step();
    chk("t6 sat5 type1", tot_type1_2, 15);
    chk("t6 sat5 words", tot_words_2, 5);
    chk("t6 wide type1", tot_type1, 20);
    in_valid = 0;
    step();

    for (int i = 0; i < 8; i++) begin
      in_codes = tbl_codes[i]; mode = tbl_mode[i]; pattern = tbl_pat[i];
      out_ready = tbl_ordy[i]; in_valid = 1;
      step();
    end
    in_valid = 0; out_ready = 1;
    step();

    // Reset while a result is held, with clear and accept pending
    out_ready = 0; in_codes = {4{3'b000}}; in_valid = 1;
    step();
    chk("t8 held", out_valid, 1);
    rst_n = 0; clear = 1;
    step();
    chk("t8 out_valid", out_valid, 0);
    chk("t8 out_types", out_types, 0);
    chk("t8 out_count", out_count, 0);
    chk("t8 tot_type1", tot_type1, 0);
    chk("t8 tot_words", tot_words, 0);
    chk("t8 in_ready", in_ready, 1);
    rst_n = 1; clear = 0; in_valid = 0;
    step();
    chk("t8 post in_ready", in_ready, 1);
    chk("t8 post out_valid", out_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
